// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer, its watchdog and the
// surrounding checker/stimulus code.
package alu_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 8;
    localparam int unsigned ALU_OP_WIDTH   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } seq_state_t;

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND = 3'b010;
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR = 3'b100;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SHL = 3'b101;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SHR = 3'b110;
    localparam logic [ALU_OP_WIDTH-1:0] OP_MUL = 3'b111;

endpackage

// File: rtl/alu_watchdog.sv
// Loadable up-counter with clear and enable; flags expiry at TIMEOUT-1.
module alu_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_clear,
    input  logic                       i_load,
    input  logic [$clog2(TIMEOUT)-1:0] i_load_value,
    input  logic                       i_enable,
    output logic                       o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts a parallel ALU command, serialises it onto the ALU bus, waits for
// done (guarded by a watchdog) and returns the result over a response handshake.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int unsigned OP_WIDTH   = ALU_OP_WIDTH,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  opcode_valid,
    output logic                  opcode,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_timeout,
    output logic                  busy
);

    localparam int unsigned BW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;

    seq_state_t            r_state;
    seq_state_t            w_state_next;
    logic [OP_WIDTH-1:0]   r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_rsp_overflow;
    logic                  r_rsp_timeout;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_abort;
    logic                  w_last_bit;
    logic                  w_expired;

    assign w_last_bit   = (r_bit == BW'(OP_WIDTH - 1));
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_timeout  = r_rsp_timeout;

    // Counter is held at zero outside WAIT so it always starts fresh on entry.
    alu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (r_state != WAIT),
        .i_load       (1'b0),
        .i_load_value ('0),
        .i_enable     (r_state == WAIT),
        .o_expired    (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        opcode_valid = 1'b0;
        opcode       = 1'b0;
        data         = '0;
        rsp_valid    = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                opcode_valid = 1'b1;
                opcode       = r_op[r_bit];
                if (r_bit == BW'(0)) begin
                    data = r_a;
                end else if (r_bit == BW'(1)) begin
                    data = r_b;
                end
                if (w_last_bit) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                // done takes priority over a coincident watchdog expiry
                if (done) begin
                    w_capture    = 1'b1;
                    w_state_next = RESP;
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_bit          <= '0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= cmd_op;
                r_a   <= cmd_a;
                r_b   <= cmd_b;
                r_bit <= '0;
            end else if (r_state == SEND) begin
                r_bit <= w_last_bit ? '0 : r_bit + BW'(1);
            end
            if (w_capture) begin
                r_rsp_result   <= result;
                r_rsp_overflow <= overflow;
                r_rsp_timeout  <= 1'b0;
            end else if (w_abort) begin
                r_rsp_result   <= '0;
                r_rsp_overflow <= 1'b0;
                r_rsp_timeout  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized checks of alu_cmd_sequencer against a cycle-level
// expectation built from command, done position and back-pressure length.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int DW  = 8;
    localparam int OPW = 3;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [OPW-1:0] cmd_op = '0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          opcode_valid;
    logic          opcode;
    logic [DW-1:0] data;
    logic          done = 1'b0;
    logic [DW-1:0] result = '0;
    logic          overflow = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic          rsp_overflow;
    logic          rsp_timeout;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic           nxt_pending = 1'b0;
    logic [OPW-1:0] nxt_op = '0;
    logic [DW-1:0]  nxt_a = '0;
    logic [DW-1:0]  nxt_b = '0;

    alu_cmd_sequencer #(
        .DATA_WIDTH (DW),
        .OP_WIDTH   (OPW),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .opcode_valid (opcode_valid),
        .opcode       (opcode),
        .data         (data),
        .done         (done),
        .result       (result),
        .overflow     (overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " opcode_valid"}, 32'(opcode_valid), 32'd0);
        check({tag, " data"}, 32'(data), 32'd0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    // Call at posedge+1 with the DUT idle. done_at is the WAIT cycle index
    // (0-based) carrying done; any value outside 0..TO-1 means done never comes.
    task automatic run_cmd(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input int done_at,
                           input logic [DW-1:0] res, input logic ovf,
                           input int hold, input bit stray, input string name);
        bit            timed_out;
        int            wait_len;
        logic [DW-1:0] exp_res;
        logic          exp_ovf;
        bit            in_send;
        int            w;
        logic [DW-1:0] exp_data;

        timed_out = !(done_at >= 0 && done_at < TO);
        wait_len  = timed_out ? TO : done_at + 1;
        exp_res   = timed_out ? '0 : res;
        exp_ovf   = timed_out ? 1'b0 : ovf;

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        check_idle({name, " accept"});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = OPW'($urandom);
        cmd_a     = DW'($urandom);
        cmd_b     = DW'($urandom);

        for (int t = 1; t <= OPW + wait_len; t++) begin
            in_send  = (t <= OPW);
            w        = t - OPW - 1;
            done     = in_send ? stray : (w == done_at);
            result   = (done && !in_send) ? res : DW'($urandom);
            overflow = (done && !in_send) ? ovf : 1'($urandom);
            exp_data = (t == 1) ? a : (t == 2) ? b : '0;
            if (!in_send) exp_data = '0;
            @(negedge clk);
            check($sformatf("%s c%0d opcode_valid", name, t), 32'(opcode_valid), 32'(in_send));
            check($sformatf("%s c%0d opcode", name, t), 32'(opcode), in_send ? 32'(op[t-1]) : 32'd0);
            check($sformatf("%s c%0d data", name, t), 32'(data), 32'(exp_data));
            check($sformatf("%s c%0d busy", name, t), 32'(busy), 32'd1);
            check($sformatf("%s c%0d cmd_ready", name, t), 32'(cmd_ready), 32'd0);
            check($sformatf("%s c%0d rsp_valid", name, t), 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end

        for (int h = 0; h <= hold; h++) begin
            rsp_ready = (h == hold);
            done      = 1'($urandom);
            result    = DW'($urandom);
            overflow  = 1'($urandom);
            if (nxt_pending) begin
                cmd_valid = 1'b1;
                cmd_op    = nxt_op;
                cmd_a     = nxt_a;
                cmd_b     = nxt_b;
            end
            @(negedge clk);
            check($sformatf("%s r%0d rsp_valid", name, h), 32'(rsp_valid), 32'd1);
            check($sformatf("%s r%0d rsp_result", name, h), 32'(rsp_result), 32'(exp_res));
            check($sformatf("%s r%0d rsp_overflow", name, h), 32'(rsp_overflow), 32'(exp_ovf));
            check($sformatf("%s r%0d rsp_timeout", name, h), 32'(rsp_timeout), 32'(timed_out));
            check($sformatf("%s r%0d cmd_ready", name, h), 32'(cmd_ready), 32'd0);
            check($sformatf("%s r%0d opcode_valid", name, h), 32'(opcode_valid), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        done      = 1'b0;
        if (!nxt_pending) cmd_valid = 1'b0;
    endtask

    initial begin
        int d;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("in_reset rsp_timeout", 32'(rsp_timeout), 32'd0);
        check_idle("in_reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");
        @(posedge clk); #1;

        // Single command, done on second WAIT cycle
        run_cmd(OP_SHL, 8'h12, 8'h34, 1, 8'h46, 1'b0, 0, 1'b0, "single");

        // Overflow capture, done on first WAIT cycle (minimum latency)
        run_cmd(OP_ADD, 8'hF0, 8'h20, 0, 8'h10, 1'b1, 0, 1'b0, "ovf");

        // Back-pressure with a second command pending during the response
        nxt_pending = 1'b1;
        nxt_op      = OP_XOR;
        nxt_a       = 8'hA5;
        nxt_b       = 8'h5A;
        run_cmd(OP_SUB, 8'h33, 8'h11, 2, 8'h22, 1'b0, 5, 1'b1, "bp");
        nxt_pending = 1'b0;
        run_cmd(nxt_op, nxt_a, nxt_b, 3, 8'hFF, 1'b0, 1, 1'b0, "bp_next");

        // Watchdog abort, then done on the final WAIT cycle
        run_cmd(OP_AND, 8'h0F, 8'hF0, -1, 8'h77, 1'b1, 0, 1'b0, "timeout");
        run_cmd(OP_OR, 8'h0F, 8'hF0, TO - 1, 8'hFF, 1'b1, 0, 1'b0, "last_wait");

        // Reset during the second SEND cycle
        cmd_valid = 1'b1;
        cmd_op    = OP_MUL;
        cmd_a     = 8'hC3;
        cmd_b     = 8'h3C;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst pre opcode_valid", 32'(opcode_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst async opcode", 32'(opcode), 32'd0);
        check("midrst async rsp_result", 32'(rsp_result), 32'd0);
        check_idle("midrst async");
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            done     = 1'b1;
            result   = DW'($urandom);
            overflow = 1'b1;
            @(negedge clk);
            check_idle($sformatf("midrst idle%0d", i));
            @(posedge clk); #1;
        end
        done = 1'b0;
        run_cmd(OP_SHR, 8'h81, 8'h18, 0, 8'h40, 1'b0, 0, 1'b0, "post_rst");

        // Randomized commands
        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 5))
                0:       d = -1;
                1:       d = TO - 1;
                default: d = int'($urandom_range(0, 5));
            endcase
            run_cmd(OPW'($urandom), DW'($urandom), DW'($urandom), d,
                    DW'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom), $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream driver stage for the simple ALU.
- Accepts one parallel command (opcode plus two operands) over a valid/ready handshake and serialises it onto the ALU's opcode_valid/opcode/data bus.
- Waits for the ALU's done, captures result and overflow, then returns them over a valid/ready response handshake.
- A watchdog aborts the wait if done never arrives.

Parameters:
- DATA_WIDTH, 8, operand/result width; must match the ALU.
- OP_WIDTH, 3, number of opcode bits; sent serially, one bit per cycle.
- TIMEOUT, 64, maximum cycles spent in WAIT before aborting; must be >= 2.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  OP_WIDTH  opcode.
- cmd_a  in  DATA_WIDTH  operand A.
- cmd_b  in  DATA_WIDTH  operand B.
- opcode_valid  out  1  to ALU: opcode/data phase active.
- opcode  out  1  to ALU: serial opcode bit.
- data  out  DATA_WIDTH  to ALU: operand bus.
- done  in  1  from ALU: result valid.
- result  in  DATA_WIDTH  from ALU.
- overflow  in  1  from ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  DATA_WIDTH  captured result.
- rsp_overflow  out  1  captured overflow.
- rsp_timeout  out  1  response is a watchdog abort.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0, except cmd_ready = 1.
  - State IDLE; all counters 0.
  - Reset asserted mid-operation abandons the command: no response is produced and the ALU bus returns to 0 immediately.
- States: IDLE, SEND, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready at edge N, register cmd_op, cmd_a and cmd_b, then go to SEND.
  - Command input values outside the accepting cycle are ignored.
- SEND, lasting OP_WIDTH cycles (bit counter k = 0..OP_WIDTH-1), occupying cycles N+1 .. N+OP_WIDTH:
  - opcode_valid = 1 and opcode = op[k], sent LSB first.
  - data = A when k = 0, B when k = 1, all zeros otherwise.
  - After the last bit, go to WAIT; opcode_valid drops to 0 and data returns to 0.
- WAIT:
  - The watchdog counter starts at 0 on entry and increments each cycle.
  - First cycle with done = 1: capture result into rsp_result and overflow into rsp_overflow (same edge), set rsp_timeout = 0, go to RESP.
  - If the counter reaches TIMEOUT-1 with done still 0: set rsp_result = 0, rsp_overflow = 0, rsp_timeout = 1, go to RESP.
  - If done and timeout coincide, done wins.
- done asserted in IDLE, SEND or RESP is ignored; it is neither captured nor counted.
- RESP:
  - rsp_valid = 1 with all rsp_* fields held stable until rsp_valid && rsp_ready.
  - On that handshake, rsp_valid goes to 0 next cycle and the state returns to IDLE.
  - cmd_ready reasserts in IDLE, so there is no command/response overlap (one command in flight).
- Latency:
  - From command accept to first opcode_valid: 1 cycle.
  - Minimum from accept to rsp_valid: OP_WIDTH + 2 cycles, when done arrives on the first WAIT cycle.
- Width rules: the operand and result paths are straight copies with no extension or truncation.

Decomposition:
- Shared package alu_pkg holds:
  - the state enum (IDLE/SEND/WAIT/RESP);
  - the default DATA_WIDTH and OP_WIDTH;
  - opcode constants shared with the ALU, checker and stimulus.
- One natural sub-module: alu_watchdog, a loadable counter with clear, enable and an expired flag. It is parameterised by TIMEOUT and is reusable by the checker.
- Everything else stays in a single FSM plus datapath registers.

Test Plan:
- Reset then idle: reset_n low for 3 cycles, then high -> cmd_ready = 1, busy = 0, opcode_valid = 0, data = 0, rsp_valid = 0.
- Single command, op = 3'b101, A = 8'h12, B = 8'h34; ALU model asserts done two cycles after SEND with result = 8'h46, overflow = 0:
  - opcode_valid high for exactly 3 cycles;
  - opcode sequence 1, 0, 1;
  - data sequence 8'h12, 8'h34, 8'h00;
  - response rsp_result = 8'h46, rsp_overflow = 0, rsp_timeout = 0.
- Overflow capture: A = 8'hF0, B = 8'h20, done with result = 8'h10 and overflow = 1 -> rsp_result = 8'h10, rsp_overflow = 1.
- Back-pressure:
  - hold rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_* stable and cmd_ready = 0 throughout;
  - drive a second cmd_valid in that window -> not accepted until after the response handshake.
- Watchdog: done never asserted -> rsp_valid after exactly TIMEOUT cycles in WAIT, with rsp_timeout = 1 and rsp_result = 0. Repeat with done on the last WAIT cycle -> normal response with rsp_timeout = 0.
- Reset mid-operation:
  - assert reset_n = 0 during the second SEND cycle -> outputs 0 asynchronously;
  - after release no response appears and cmd_ready = 1;
  - a stray done = 1 in IDLE is ignored.
